// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the zone encoding shared by the axis counters.
// No logic; no latency or flow control.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 12;

    typedef enum logic [1:0] {
        ZONE_ACTIVE = 2'd0,
        ZONE_FP     = 2'd1,
        ZONE_SYNC   = 2'd2,
        ZONE_BP     = 2'd3
    } vga_zone_e;

    // True when a counter of width cw can hold total-1.
    function automatic bit fits_cw(input int total, input int cw);
        return (cw > 0) && (cw < 31) && ((total - 1) < (1 << cw));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-advance enable in, registered sync/DE/coordinates/strobes out.
// Pure wiring; the enable is the only flow control and simply stalls the raster.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          i_Enable;
    logic          o_HSync;
    logic          o_VSync;
    logic          o_Active;
    logic [CW-1:0] o_HPos;
    logic [CW-1:0] o_VPos;
    logic          o_LineStart;
    logic          o_FrameStart;

    modport master (
        input  i_Enable,
        output o_HSync, o_VSync, o_Active, o_HPos, o_VPos, o_LineStart, o_FrameStart
    );

    modport slave (
        output i_Enable,
        input  o_HSync, o_VSync, o_Active, o_HPos, o_VPos, o_LineStart, o_FrameStart
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with combinational zone decode and wrap flag.
// Count updates one cycle after i_Step; o_Wrap/zone describe the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          i_Clk,
    input  logic          i_Reset,
    input  logic          i_Step,
    output logic [CW-1:0] count,
    output logic          o_Wrap,
    output vga_zone_e     zone
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FP_START   = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BP_START   = CW'(ACTIVE + FP + SYNC);

    assign o_Wrap = (count == LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count <= '0;
        end else if (i_Step) begin
            count <= o_Wrap ? '0 : count + CW'(1);
        end
    end

    always_comb begin
        zone = ZONE_BP;
        if (count < FP_START) begin
            zone = ZONE_ACTIVE;
        end else if (count < SYNC_START) begin
            zone = ZONE_FP;
        end else if (count < BP_START) begin
            zone = ZONE_SYNC;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: H/V axis counters plus one output register stage.
// Outputs describe the (h,v) sampled on the same enable edge; i_Enable low freezes everything.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   CW         = DEF_CW
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_zone
        $fatal(1, "vga_timing_gen: every active/porch/sync parameter must be non-zero");
    end

    if (!fits_cw(H_TOTAL, CW) || !fits_cw(V_TOTAL, CW)) begin : g_bad_cw
        $fatal(1, "vga_timing_gen: CW too small for H_TOTAL-1 or V_TOTAL-1");
    end

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;
    vga_zone_e     h_zone;
    vga_zone_e     v_zone;
    logic          v_step;

    assign v_step = h_wrap & vga.i_Enable;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h_axis (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Step  (vga.i_Enable),
        .count   (h_count),
        .o_Wrap  (h_wrap),
        .zone    (h_zone)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v_axis (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Step  (v_step),
        .count   (v_count),
        .o_Wrap  (v_wrap),
        .zone    (v_zone)
    );

    // Output stage samples the same (h,v) the counters step away from, so all outputs stay aligned.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            vga.o_HSync      <= ~H_SYNC_POL;
            vga.o_VSync      <= ~V_SYNC_POL;
            vga.o_Active     <= 1'b0;
            vga.o_HPos       <= '0;
            vga.o_VPos       <= '0;
            vga.o_LineStart  <= 1'b0;
            vga.o_FrameStart <= 1'b0;
        end else if (vga.i_Enable) begin
            vga.o_HSync      <= (h_zone == ZONE_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vga.o_VSync      <= (v_zone == ZONE_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            vga.o_Active     <= (h_zone == ZONE_ACTIVE) && (v_zone == ZONE_ACTIVE);
            vga.o_HPos       <= h_count;
            vga.o_VPos       <= v_count;
            vga.o_LineStart  <= (h_count == '0);
            vga.o_FrameStart <= (h_count == '0) && (v_count == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three raster configurations driven by shared enable/reset, checked against a pixel-index model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic [15:0] hp;
        logic [15:0] vp;
        logic        ls;
        logic        fs;
    } out_t;

    localparam int NI = 3;
    // Instance 0: medium raster, mixed polarity. 1: tiny 2/1/1/1. 2: defaults.
    localparam int HA [NI] = '{16, 2, 640};
    localparam int HF [NI] = '{2, 1, 16};
    localparam int HS [NI] = '{3, 1, 96};
    localparam int HB [NI] = '{4, 1, 48};
    localparam int VA [NI] = '{10, 2, 480};
    localparam int VF [NI] = '{2, 1, 10};
    localparam int VS [NI] = '{2, 1, 2};
    localparam int VB [NI] = '{3, 1, 33};
    localparam int HP [NI] = '{0, 1, 0};
    localparam int VP [NI] = '{1, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(6))  if_a ();
    vga_timing_gen_if #(.CW(4))  if_b ();
    vga_timing_gen_if #(.CW(12)) if_c ();

    assign if_a.i_Enable = enable;
    assign if_b.i_Enable = enable;
    assign if_c.i_Enable = enable;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .CW(6)
    ) dut_a (.i_Clk(clk), .i_Reset(rst), .vga(if_a));

    vga_timing_gen #(
        .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CW(4)
    ) dut_b (.i_Clk(clk), .i_Reset(rst), .vga(if_b));

    vga_timing_gen dut_c (.i_Clk(clk), .i_Reset(rst), .vga(if_c));

    out_t got_a, got_b, got_c;
    assign got_a = {if_a.o_HSync, if_a.o_VSync, if_a.o_Active, 16'(if_a.o_HPos), 16'(if_a.o_VPos),
                    if_a.o_LineStart, if_a.o_FrameStart};
    assign got_b = {if_b.o_HSync, if_b.o_VSync, if_b.o_Active, 16'(if_b.o_HPos), 16'(if_b.o_VPos),
                    if_b.o_LineStart, if_b.o_FrameStart};
    assign got_c = {if_c.o_HSync, if_c.o_VSync, if_c.o_Active, 16'(if_c.o_HPos), 16'(if_c.o_VPos),
                    if_c.o_LineStart, if_c.o_FrameStart};

    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    longint n [NI];
    out_t   exp_o [NI];
    out_t   q0 [$];
    out_t   q1 [$];
    out_t   q2 [$];

    // Pixel idx (enable cycles since reset) maps directly onto raster position.
    function automatic out_t ref_out(input int i, input longint idx);
        out_t o;
        int ht = HA[i] + HF[i] + HS[i] + HB[i];
        int vt = VA[i] + VF[i] + VS[i] + VB[i];
        int h  = int'(idx % longint'(ht));
        int v  = int'((idx / longint'(ht)) % longint'(vt));
        logic hpol = (HP[i] != 0);
        logic vpol = (VP[i] != 0);
        o.hs  = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? hpol : ~hpol;
        o.vs  = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? vpol : ~vpol;
        o.act = (h < HA[i]) && (v < VA[i]);
        o.hp  = 16'(h);
        o.vp  = 16'(v);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic out_t rst_out(input int i);
        out_t o;
        o     = '0;
        o.hs  = (HP[i] == 0);
        o.vs  = (VP[i] == 0);
        return o;
    endfunction

    task automatic push(input int i, input out_t o);
        case (i)
            0:       q0.push_back(o);
            1:       q1.push_back(o);
            default: q2.push_back(o);
        endcase
    endtask

    task automatic step(input logic en, input logic r);
        @(negedge clk);
        enable = en;
        rst    = r;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                exp_o[i] = rst_out(i);
                n[i]     = 0;
            end else if (en) begin
                exp_o[i] = ref_out(i, n[i]);
                n[i]     = n[i] + 1;
            end
            push(i, exp_o[i]);
        end
        mon_en = 1'b1;
    endtask

    task automatic cmp(input string nm, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got hs=%b vs=%b act=%b h=%0d v=%0d ls=%b fs=%b want hs=%b vs=%b act=%b h=%0d v=%0d ls=%b fs=%b",
                     nm, $time, got.hs, got.vs, got.act, got.hp, got.vp, got.ls, got.fs,
                     want.hs, want.vs, want.act, want.hp, want.vp, want.ls, want.fs);
        end
    endtask

    task automatic underflow(input string nm);
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty at t=%0t", nm, $time);
    endtask

    initial begin
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() == 0) underflow("dut_a"); else cmp("dut_a", got_a, q0.pop_front());
            if (q1.size() == 0) underflow("dut_b"); else cmp("dut_b", got_b, q1.pop_front());
            if (q2.size() == 0) underflow("dut_c"); else cmp("dut_c", got_c, q2.pop_front());
        end
    end

    initial begin
        bit found;
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (900) step(1'b1, 1'b0);
        repeat (60) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (800) step(1'($urandom_range(0, 3) != 0), 1'b0);

        // Park dut_a inside both sync pulses, then reset there.
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (exp_o[0].hs == 1'b0 && exp_o[0].vs == 1'b1) found = 1'b1;
            else step(1'b1, 1'b0);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL mid_sync_search bound expired got none want hsync&vsync asserted");
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (400) step(1'b1, 1'b0);
        repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
        step(1'b0, 1'b0);

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
